// File: rtl/seq_hit_monitor_if.sv
// Result channel of seq_hit_monitor: window count plus valid/ready handshake.
// The monitor drives the master side and the downstream consumer drives the slave side.
interface seq_hit_monitor_if #(
  parameter int CNT_W = 8
);
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_valid;
  logic             cnt_ready;

  modport master (
    output cnt_out,
    output cnt_valid,
    input  cnt_ready
  );

  modport slave (
    input  cnt_out,
    input  cnt_valid,
    output cnt_ready
  );
endinterface

// File: rtl/seq_hit_monitor.sv
// Counts sequence-detector hits over windows of WIN_LEN enabled cycles.
// Each window's count is offered on a valid/ready channel, with a threshold alarm and a sticky overrun flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | no unconsumed result; the next window close loads cnt_out
// S_FULL  | cnt_out holds a result that the consumer has not taken yet
module seq_hit_monitor #(
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int THRESH  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                hit_i,
  input  logic                clr_overrun_i,
  seq_hit_monitor_if.master   res_if,
  output logic                alarm_o,
  output logic                overrun_o
);

  localparam int               WIN_W    = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam int unsigned      THRESH_U = THRESH;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] cnt_out_q;
  logic             cnt_valid_q;
  logic             alarm_q;
  logic             overrun_q;

  logic [CNT_W:0]   hit_sum;
  logic [CNT_W-1:0] hit_sat;
  logic             win_close;
  logic             drop;

  // hit_sat already includes a hit on the closing cycle, so it is the window's final count.
  assign hit_sum   = {1'b0, hit_cnt_q} + {{CNT_W{1'b0}}, hit_i};
  assign hit_sat   = hit_sum[CNT_W] ? CNT_MAX : hit_sum[CNT_W-1:0];
  assign win_close = en_i && (win_cnt_q == WIN_LAST);
  assign drop      = win_close && (state_q == S_FULL) && !res_if.cnt_ready;

  always_comb begin
    win_cnt_d = win_cnt_q;
    hit_cnt_d = hit_cnt_q;
    if (en_i) begin
      if (win_close) begin
        win_cnt_d = '0;
        hit_cnt_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        hit_cnt_d = hit_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      cnt_out_q   <= '0;
      cnt_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      alarm_q <= win_close && (32'(hit_sat) >= THRESH_U);

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun_i) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        S_EMPTY: begin
          if (win_close) begin
            cnt_out_q   <= hit_sat;
            cnt_valid_q <= 1'b1;
            state_q     <= S_FULL;
          end
        end
        S_FULL: begin
          if (res_if.cnt_ready) begin
            if (win_close) begin
              cnt_out_q <= hit_sat;
            end else begin
              cnt_valid_q <= 1'b0;
              state_q     <= S_EMPTY;
            end
          end
        end
        default: begin
          cnt_valid_q <= 1'b0;
          state_q     <= S_EMPTY;
        end
      endcase
    end
  end

  assign res_if.cnt_out   = cnt_out_q;
  assign res_if.cnt_valid = cnt_valid_q;
  assign alarm_o          = alarm_q;
  assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Bench for seq_hit_monitor: directed scenarios plus a randomized run against a window-level reference model.
// A second instance with CNT_W=4, WIN_LEN=32 covers hit-count saturation.
module tb_seq_hit_monitor;

  localparam int WIN_LEN = 16;
  localparam int THRESH  = 3;
  localparam int MAXC    = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en, hit, clr;
  logic alarm, ovr;
  logic en2, hit2, clr2;
  logic alarm2, ovr2;

  int vecs = 0;
  int errs = 0;

  // Reference model state: position inside the window, hits so far, and the output channel.
  int m_pos, m_hits, m_out;
  bit m_valid, m_alarm, m_ovr;

  seq_hit_monitor_if #(.CNT_W(8)) rif ();
  seq_hit_monitor_if #(.CNT_W(4)) rif2 ();

  seq_hit_monitor #(.WIN_LEN(16), .CNT_W(8), .THRESH(3)) dut (
    .clk(clk), .rst(rst), .en_i(en), .hit_i(hit), .clr_overrun_i(clr),
    .res_if(rif), .alarm_o(alarm), .overrun_o(ovr)
  );

  seq_hit_monitor #(.WIN_LEN(32), .CNT_W(4), .THRESH(3)) dut_sat (
    .clk(clk), .rst(rst), .en_i(en2), .hit_i(hit2), .clr_overrun_i(clr2),
    .res_if(rif2), .alarm_o(alarm2), .overrun_o(ovr2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos = 0; m_hits = 0; m_out = 0;
    m_valid = 0; m_alarm = 0; m_ovr = 0;
  endtask

  // Apply one cycle of inputs, advance the model by the same edge, and return #1 after that edge.
  task automatic step(input logic e, input logic h, input logic r, input logic c);
    int  fin;
    bit  close;
    en = e; hit = h; rif.cnt_ready = r; clr = c;
    @(posedge clk);
    close = e && (m_pos == WIN_LEN - 1);
    fin   = m_hits + int'(h);
    if (fin > MAXC) fin = MAXC;
    if (e) begin
      if (close) begin
        m_pos = 0; m_hits = 0;
      end else begin
        m_pos = m_pos + 1; m_hits = fin;
      end
    end
    m_alarm = close && (fin >= THRESH);
    if (close && m_valid && !r) m_ovr = 1;
    else if (c) m_ovr = 0;
    if (close && !(m_valid && !r)) begin
      m_out = fin; m_valid = 1;
    end else if (m_valid && r) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    en = 0; hit = 0; clr = 0; rif.cnt_ready = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    en = 0; hit = 0; clr = 0; rif.cnt_ready = 0;
    en2 = 0; hit2 = 0; clr2 = 0; rif2.cnt_ready = 0;
    rst = 1'b1;
    #1;
    vecs++; if (rif.cnt_out !== 8'd0) begin errs++; $display("FAIL reset_cnt_out got=%0d exp=0", rif.cnt_out); end
    vecs++; if (rif.cnt_valid !== 1'b0) begin errs++; $display("FAIL reset_cnt_valid got=%b exp=0", rif.cnt_valid); end
    vecs++; if (alarm !== 1'b0) begin errs++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
    vecs++; if (ovr !== 1'b0) begin errs++; $display("FAIL reset_overrun got=%b exp=0", ovr); end
    @(posedge clk); #1;
    vecs++; if (rif.cnt_valid !== 1'b0) begin errs++; $display("FAIL reset_held_valid got=%b exp=0", rif.cnt_valid); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, (i == 2 || i == 5 || i == 9), 1'b1, 1'b0);
    vecs++; if (rif.cnt_out !== 8'd3) begin errs++; $display("FAIL basic_cnt_out got=%0d exp=3", rif.cnt_out); end
    vecs++; if (rif.cnt_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got=%b exp=1", rif.cnt_valid); end
    vecs++; if (alarm !== 1'b1) begin errs++; $display("FAIL basic_alarm got=%b exp=1", alarm); end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    vecs++; if (rif.cnt_valid !== 1'b0) begin errs++; $display("FAIL basic_valid_consumed got=%b exp=0", rif.cnt_valid); end
    vecs++; if (alarm !== 1'b0) begin errs++; $display("FAIL basic_alarm_pulse got=%b exp=0", alarm); end
  endtask

  task automatic test_last_hit();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, (i == 15), 1'b1, 1'b0);
    vecs++; if (rif.cnt_out !== 8'd1) begin errs++; $display("FAIL last_hit_cnt_out got=%0d exp=1", rif.cnt_out); end
    vecs++; if (alarm !== 1'b0) begin errs++; $display("FAIL last_hit_alarm got=%b exp=0", alarm); end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    vecs++; if (rif.cnt_out !== 8'd0) begin errs++; $display("FAIL last_hit_next_window got=%0d exp=0", rif.cnt_out); end
    vecs++; if (rif.cnt_valid !== 1'b1) begin errs++; $display("FAIL last_hit_next_valid got=%b exp=1", rif.cnt_valid); end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, (i == 1 || i == 4), 1'b0, 1'b0);
    vecs++; if (ovr !== 1'b0) begin errs++; $display("FAIL ovr_first_window got=%b exp=0", ovr); end
    for (int i = 0; i < 16; i++) step(1'b1, (i % 3 == 0 && i < 13), 1'b0, 1'b0);
    vecs++; if (ovr !== 1'b1) begin errs++; $display("FAIL ovr_set got=%b exp=1", ovr); end
    vecs++; if (rif.cnt_out !== 8'd2) begin errs++; $display("FAIL ovr_held_cnt got=%0d exp=2", rif.cnt_out); end
    vecs++; if (rif.cnt_valid !== 1'b1) begin errs++; $display("FAIL ovr_held_valid got=%b exp=1", rif.cnt_valid); end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    vecs++; if (ovr !== 1'b0) begin errs++; $display("FAIL ovr_clear got=%b exp=0", ovr); end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    vecs++; if (rif.cnt_valid !== 1'b0) begin errs++; $display("FAIL ovr_transfer_valid got=%b exp=0", rif.cnt_valid); end
    vecs++; if (rif.cnt_out !== 8'd2) begin errs++; $display("FAIL ovr_transfer_cnt got=%0d exp=2", rif.cnt_out); end
  endtask

  task automatic test_ready_on_close();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, (i == 3 || i == 7), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, (i < 4), (i == 15), 1'b0);
    vecs++; if (rif.cnt_out !== 8'd4) begin errs++; $display("FAIL b2b_cnt_out got=%0d exp=4", rif.cnt_out); end
    vecs++; if (rif.cnt_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid got=%b exp=1", rif.cnt_valid); end
    vecs++; if (ovr !== 1'b0) begin errs++; $display("FAIL b2b_overrun got=%b exp=0", ovr); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, (i == 1 || i == 3), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, (i == 2), 1'b0, 1'b0);
    vecs++; if (rif.cnt_valid !== 1'b0) begin errs++; $display("FAIL stall_early_valid got=%b exp=0", rif.cnt_valid); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    vecs++; if (rif.cnt_valid !== 1'b1) begin errs++; $display("FAIL stall_close_valid got=%b exp=1", rif.cnt_valid); end
    vecs++; if (rif.cnt_out !== 8'd3) begin errs++; $display("FAIL stall_cnt_out got=%0d exp=3", rif.cnt_out); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, (i < 4), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    vecs++; if (rif.cnt_valid !== 1'b1) begin errs++; $display("FAIL areset_pre_valid got=%b exp=1", rif.cnt_valid); end
    rst = 1'b1;
    #2;
    vecs++; if (rif.cnt_valid !== 1'b0) begin errs++; $display("FAIL areset_valid got=%b exp=0", rif.cnt_valid); end
    vecs++; if (rif.cnt_out !== 8'd0) begin errs++; $display("FAIL areset_cnt_out got=%0d exp=0", rif.cnt_out); end
    vecs++; if (ovr !== 1'b0 || alarm !== 1'b0) begin errs++; $display("FAIL areset_flags got=%b%b exp=00", ovr, alarm); end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 15; i++) step(1'b1, (i == 3 || i == 8), 1'b0, 1'b0);
    vecs++; if (rif.cnt_valid !== 1'b0) begin errs++; $display("FAIL areset_early_valid got=%b exp=0", rif.cnt_valid); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    vecs++; if (rif.cnt_valid !== 1'b1) begin errs++; $display("FAIL areset_result_valid got=%b exp=1", rif.cnt_valid); end
    vecs++; if (rif.cnt_out !== 8'd2) begin errs++; $display("FAIL areset_result_cnt got=%0d exp=2", rif.cnt_out); end
  endtask

  task automatic test_saturation();
    do_reset();
    en2 = 1'b1; hit2 = 1'b1; rif2.cnt_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (i == 30) begin
        vecs++; if (rif2.cnt_valid !== 1'b0) begin errs++; $display("FAIL sat_early_valid got=%b exp=0", rif2.cnt_valid); end
      end
    end
    vecs++; if (rif2.cnt_out !== 4'd15) begin errs++; $display("FAIL sat_cnt_out got=%0d exp=15", rif2.cnt_out); end
    vecs++; if (rif2.cnt_valid !== 1'b1) begin errs++; $display("FAIL sat_valid got=%b exp=1", rif2.cnt_valid); end
    vecs++; if (alarm2 !== 1'b1) begin errs++; $display("FAIL sat_alarm got=%b exp=1", alarm2); end
    en2 = 1'b0; hit2 = 1'b0; rif2.cnt_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] e_out;
    do_reset();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
      e_out = 8'(m_out);
      vecs++; if (rif.cnt_out !== e_out) begin errs++; $display("FAIL rand_cnt_out cyc=%0d got=%0d exp=%0d", cyc, rif.cnt_out, e_out); end
      vecs++; if (rif.cnt_valid !== m_valid) begin errs++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, rif.cnt_valid, m_valid); end
      vecs++; if (alarm !== m_alarm) begin errs++; $display("FAIL rand_alarm cyc=%0d got=%b exp=%b", cyc, alarm, m_alarm); end
      vecs++; if (ovr !== m_ovr) begin errs++; $display("FAIL rand_overrun cyc=%0d got=%b exp=%b", cyc, ovr, m_ovr); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_hit();
    test_overrun();
    test_ready_on_close();
    test_stall();
    test_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
